redun_mont_collapse: RTL and testbench

// - Sink for the redun_mont result stream: takes one redundant Montgomery result (i_mul/i_val), propagates carries to

---
 rtl/redun_mont_pkg.sv | 22 ++
 rtl/redun_carry_slice.sv | 31 +++
 rtl/redun_mont_collapse.sv | 128 ++++++++++++
 tb/tb_redun_mont_collapse.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/redun_mont_pkg.sv
// Shared constants and types for the redundant Montgomery datapath and its
// result collapse stage.
package redun_mont_pkg;

    localparam int NUM_WRDS   = 32;
    localparam int WRD_BITS   = 8;
    localparam int CANON_BITS = NUM_WRDS * WRD_BITS;

    // Modulus 2^255 - 19
    localparam logic [CANON_BITS-1:0] P = {1'b0, {(CANON_BITS-1){1'b1}}} - CANON_BITS'(18);

    // Word i carries WRD_BITS payload bits plus one redundant bit.
    typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_COLLAPSE = 4'b0010,
        ST_REDUCE   = 4'b0100,
        ST_OUT      = 4'b1000
    } collapse_state_t;

endpackage

// File: rtl/redun_carry_slice.sv
// Combinational carry propagation across one group of redundant words,
// producing canonical payload words and the carry into the next group.
module redun_carry_slice
    import redun_mont_pkg::*;
#(
    parameter int WRD_BITS = redun_mont_pkg::WRD_BITS,
    parameter int WRDS     = 8
) (
    input  logic [WRDS-1:0][WRD_BITS:0] i_wrd,
    input  logic [1:0]                  i_carry,
    output logic [WRDS*WRD_BITS-1:0]    o_wrd,
    output logic [1:0]                  o_carry
);

    logic [WRD_BITS+1:0] sum;
    logic [1:0]          chain;

    // Max per-word sum is (2^(W+1)-1)+3, so the carry never exceeds 2 bits.
    always_comb begin
        sum   = '0;
        chain = i_carry;
        o_wrd = '0;
        for (int i = 0; i < WRDS; i++) begin
            sum = {1'b0, i_wrd[i]} + {{WRD_BITS{1'b0}}, chain};
            o_wrd[i*WRD_BITS +: WRD_BITS] = sum[WRD_BITS-1:0];
            chain = sum[WRD_BITS+1:WRD_BITS];
        end
        o_carry = chain;
    end

endmodule

// File: rtl/redun_mont_collapse.sv
// Collapses one redundant Montgomery result to canonical binary, reduces it
// into [0, P) by bounded conditional subtraction, and hands it off valid/ready.
module redun_mont_collapse
    import redun_mont_pkg::*;
#(
    parameter int NUM_WRDS     = redun_mont_pkg::NUM_WRDS,
    parameter int WRD_BITS     = redun_mont_pkg::WRD_BITS,
    parameter int WRDS_PER_CYC = 8,
    parameter int MAX_SUB      = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  redun0_t                      i_mul,
    input  logic                         i_val,
    output logic [NUM_WRDS*WRD_BITS-1:0] o_dat,
    output logic                         o_val,
    input  logic                         i_rdy,
    output logic                         o_drop,
    output logic                         o_err
);

    localparam int N_BITS     = NUM_WRDS * WRD_BITS;
    localparam int ACC_W      = N_BITS + 2;
    localparam int NUM_GRP    = NUM_WRDS / WRDS_PER_CYC;
    localparam int GRP_W      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int CNT_W      = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;
    localparam int SLICE_BITS = WRDS_PER_CYC * WRD_BITS;

    collapse_state_t state;
    redun0_t         wrd;
    logic [ACC_W-1:0] acc;
    logic [1:0]       carry;
    logic [GRP_W-1:0] grp;
    logic [CNT_W-1:0] sub_cnt;

    logic [WRDS_PER_CYC-1:0][WRD_BITS:0] slice_in;
    logic [SLICE_BITS-1:0]               slice_out;
    logic [1:0]                          slice_cout;
    logic [ACC_W-1:0]                    diff;
    logic                                borrow;
    logic                                last_grp;
    logic                                sub_done;

    assign slice_in = wrd[int'(grp)*WRDS_PER_CYC +: WRDS_PER_CYC];
    assign last_grp = (grp == GRP_W'(NUM_GRP - 1));
    assign sub_done = (sub_cnt == CNT_W'(MAX_SUB));
    assign {borrow, diff} = {1'b0, acc} - {1'b0, ACC_W'(P)};

    redun_carry_slice #(
        .WRD_BITS (WRD_BITS),
        .WRDS     (WRDS_PER_CYC)
    ) u_slice (
        .i_wrd   (slice_in),
        .i_carry (carry),
        .o_wrd   (slice_out),
        .o_carry (slice_cout)
    );

    // Datapath registers: captured words and the accumulator
    always_ff @(posedge i_clk) begin
        if (state == ST_IDLE && i_val)
            wrd <= i_mul;
        if (state == ST_COLLAPSE) begin
            acc[int'(grp)*SLICE_BITS +: SLICE_BITS] <= slice_out;
            if (last_grp)
                acc[ACC_W-1 -: 2] <= slice_cout;
        end
        if (state == ST_REDUCE && !borrow && !sub_done)
            acc <= diff;
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            o_val   <= 1'b0;
            o_drop  <= 1'b0;
            o_err   <= 1'b0;
            o_dat   <= '0;
            carry   <= '0;
            grp     <= '0;
            sub_cnt <= '0;
        end else begin
            if (i_val && state != ST_IDLE)
                o_drop <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (i_val) begin
                        carry   <= '0;
                        grp     <= '0;
                        sub_cnt <= '0;
                        state   <= ST_COLLAPSE;
                    end
                end
                ST_COLLAPSE: begin
                    carry <= slice_cout;
                    if (last_grp)
                        state <= ST_REDUCE;
                    else
                        grp <= grp + 1'b1;
                end
                ST_REDUCE: begin
                    if (borrow) begin
                        state <= ST_OUT;
                    end else if (sub_done) begin
                        o_err <= 1'b1;
                        state <= ST_OUT;
                    end else begin
                        sub_cnt <= sub_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    // First OUT cycle loads the output register; o_dat is then
                    // held until the consumer takes it.
                    if (!o_val) begin
                        o_val <= 1'b1;
                        o_dat <= acc[N_BITS-1:0];
                    end else if (i_rdy) begin
                        o_val <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_redun_mont_collapse.sv
// Bench for redun_mont_collapse: directed vector table, hand-written handshake,
// drop and reset sequences, then random operands against an arithmetic model.
module tb_redun_mont_collapse;
    import redun_mont_pkg::*;

    localparam int C_CYC = NUM_WRDS / 8;
    localparam int MAXS  = 3;
    localparam int VW    = CANON_BITS + 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  i_val = 1'b0;
    logic                  i_rdy = 1'b0;
    redun0_t               i_mul = '0;
    logic [CANON_BITS-1:0] o_dat;
    logic                  o_val, o_drop, o_err;

    int n_run  = 0;
    int n_fail = 0;
    bit exp_drop = 1'b0;
    bit exp_err  = 1'b0;

    always #5 clk = ~clk;

    redun_mont_collapse #(
        .NUM_WRDS     (NUM_WRDS),
        .WRD_BITS     (WRD_BITS),
        .WRDS_PER_CYC (8),
        .MAX_SUB      (MAXS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_mul   (i_mul),
        .i_val   (i_val),
        .o_dat   (o_dat),
        .o_val   (o_val),
        .i_rdy   (i_rdy),
        .o_drop  (o_drop),
        .o_err   (o_err)
    );

    typedef struct {
        redun0_t               w;
        logic [CANON_BITS-1:0] dat;
        bit                    err;
        int                    k;
        string                 nm;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Integer value of the redundant operand, then bounded subtraction of P.
    function automatic void model(input redun0_t w, output logic [CANON_BITS-1:0] o,
                                  output bit e, output int k);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_WRDS; i++)
            v += VW'(w[i]) << (WRD_BITS * i);
        k = 0;
        while (v >= VW'(P) && k < MAXS) begin
            v -= VW'(P);
            k++;
        end
        e = (v >= VW'(P));
        o = v[CANON_BITS-1:0];
    endfunction

    function automatic redun0_t enc(input logic [CANON_BITS-1:0] v, input bit redund);
        redun0_t w;
        for (int i = 0; i < NUM_WRDS; i++)
            w[i] = {1'b0, v[i*WRD_BITS +: WRD_BITS]};
        if (redund && w[1] != 0 && w[0] < 256) begin
            w[1] = w[1] - 1'b1;
            w[0] = w[0] + 9'd256;
        end
        return w;
    endfunction

    function automatic redun0_t rand_w();
        redun0_t w;
        for (int i = 0; i < NUM_WRDS - 1; i++)
            w[i] = 9'($urandom_range(0, 511));
        w[NUM_WRDS-1] = 9'($urandom_range(0, 400));
        return w;
    endfunction

    task automatic run_op(input redun0_t w, input logic [CANON_BITS-1:0] exp_dat,
                          input bit e, input int k, input int hold, input bit inject,
                          input string nm);
        int cnt;
        bit stable;
        i_mul = w;
        i_val = 1'b1;
        tick();
        cnt = 1;
        while (!o_val && cnt < 100) begin
            if (inject && cnt == 2) begin
                i_mul = ~w;
                i_val = 1'b1;
            end else begin
                i_val = 1'b0;
            end
            tick();
            cnt++;
        end
        i_val = 1'b0;
        if (inject) exp_drop = 1'b1;
        exp_err = exp_err | e;
        chk({nm, " valid"}, o_val, 1);
        if (!o_val) return;
        chk({nm, " latency"}, cnt, C_CYC + k + 3);
        chk({nm, " data"}, o_dat, exp_dat);
        chk({nm, " err"}, o_err, exp_err);
        chk({nm, " drop"}, o_drop, exp_drop);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (o_val !== 1'b1 || o_dat !== exp_dat) stable = 1'b0;
        end
        if (hold > 0) chk({nm, " hold"}, stable, 1);
        i_rdy = 1'b1;
        tick();
        i_rdy = 1'b0;
        chk({nm, " handoff"}, o_val, 0);
        chk({nm, " dat kept"}, o_dat, exp_dat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [CANON_BITS-1:0] v, ed;
        redun0_t               w;
        bit                    ee;
        int                    ek;
        bit                    quiet;

        rst_n = 1'b0;
        tick();
        tick();
        chk("reset o_val", o_val, 0);
        chk("reset o_drop", o_drop, 0);
        chk("reset o_err", o_err, 0);
        chk("reset o_dat", o_dat, 0);
        rst_n = 1'b1;
        tick();

        tbl[0] = '{'0, '0, 1'b0, 0, "zeros"};
        w = '0;
        w[0] = 9'd256;
        tbl[1] = '{w, CANON_BITS'(256), 1'b0, 0, "redund_bit0"};
        v = P + 5;
        tbl[2] = '{enc(v, 1'b0), CANON_BITS'(5), 1'b0, 1, "p_plus_5"};
        v = (P << 1) + 7;
        tbl[3] = '{enc(v, 1'b0), CANON_BITS'(7), 1'b0, 2, "2p_plus_7"};
        v = P + 5;
        tbl[4] = '{enc(v, 1'b1), CANON_BITS'(5), 1'b0, 1, "p_plus_5_redund"};
        v = P - 1;
        tbl[5] = '{enc(v, 1'b0), P - 1, 1'b0, 0, "p_minus_1"};
        tbl[6] = '{enc(P, 1'b0), '0, 1'b0, 1, "exactly_p"};
        for (int i = 0; i < NUM_WRDS; i++) w[i] = 9'h1ff;
        model(w, ed, ee, ek);
        tbl[7] = '{w, ed, ee, ek, "all_max"};

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].w, tbl[i].dat, tbl[i].err, tbl[i].k, 0, 1'b0, tbl[i].nm);

        v = (P << 1) + 7;
        run_op(enc(v, 1'b0), CANON_BITS'(7), 1'b0, 2, 20, 1'b0, "hold20");

        w = rand_w();
        model(w, ed, ee, ek);
        run_op(w, ed, ee, ek, 0, 1'b1, "drop_first");
        v = P + 5;
        run_op(enc(v, 1'b0), CANON_BITS'(5), 1'b0, 1, 0, 1'b0, "after_drop");

        // Reset while the third carry group is being folded
        v = P + 5;
        i_mul = enc(v, 1'b0);
        i_val = 1'b1;
        tick();
        i_val = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_drop = 1'b0;
        exp_err  = 1'b0;
        chk("midreset o_val", o_val, 0);
        chk("midreset o_drop", o_drop, 0);
        chk("midreset o_err", o_err, 0);
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (o_val !== 1'b0) quiet = 1'b0;
        end
        chk("midreset aborted silent", quiet, 1);
        v = (P << 1) + 7;
        run_op(enc(v, 1'b1), CANON_BITS'(7), 1'b0, 2, 0, 1'b0, "post_reset");

        for (int n = 0; n < 25; n++) begin
            w = rand_w();
            model(w, ed, ee, ek);
            run_op(w, ed, ee, ek, $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
